blink_monitor: RTL

Checker for the 8-bit blink-counter bus driven by the LED counter block. It samples the bus every clock and detects each value change. It measures the cycle interval between changes and verifies that each step is +1 mod 256 and that the interval matches the programmed blink period. It reports lock status and error counts for board bring-up and for self-checking in the tile.

---
 rtl/blink_monitor_if.sv | 38 +++
 rtl/blink_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/blink_monitor_if.sv
// blink_monitor_if: bundles the monitored counter bus with the checker's
// status outputs so the monitor and whatever drives or observes it share
// one typed connection.
//
// Signals:
//   q_in        monitored counter bus (driven by the counter side)
//   period      last measured interval between changes, in cycles
//   step_valid  one-cycle pulse per measured step
//   step_err    one-cycle pulse: step was not previous+1 (mod 2^WIDTH)
//   period_err  one-cycle pulse: interval out of range, or timeout
//   locked      high after the required run of good steps
//   err_count   saturating count of error cycles
//
// Modports:
//   master  counter / observer side: drives q_in, reads status
//   slave   monitor side: reads q_in, drives status
interface blink_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 25
);
  logic [WIDTH-1:0] q_in;
  logic [CNT_W-1:0] period;
  logic             step_valid;
  logic             step_err;
  logic             period_err;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output q_in,
    input  period, step_valid, step_err, period_err, locked, err_count
  );

  modport slave (
    input  q_in,
    output period, step_valid, step_err, period_err, locked, err_count
  );
endinterface

// File: rtl/blink_monitor.sv
// blink_monitor: watches an LED blink-counter bus, measures the number of
// clock cycles between value changes, and checks that every change is a
// +1 (mod 2^WIDTH) step arriving within EXP_PERIOD +/- TOL cycles.
// Reports lock status once LOCK_N consecutive good steps have been seen and
// keeps a saturating count of error cycles.
//
// Ports:
//   clk  single clock, all logic on the rising edge
//   rst  asynchronous, active-low reset
//   bus  blink_monitor_if.slave: q_in in; period, step_valid, step_err,
//        period_err, locked, err_count out (all outputs registered)
//
// Parameters:
//   WIDTH       width of the monitored bus
//   CNT_W       width of the interval timer and of period
//   EXP_PERIOD  expected cycles between changes
//   TOL         allowed deviation of the interval, +/- cycles
//   LOCK_N      consecutive good steps needed to assert locked
module blink_monitor #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 25,
  parameter int EXP_PERIOD = 25000000,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 3
) (
  input  logic            clk,
  input  logic            rst,
  blink_monitor_if.slave  bus
);

  localparam logic [1:0] PRIME   = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam int SW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [SW-1:0] LOCK_S = SW'(LOCK_N);

  // Timer value at which the interval has reached the upper tolerance;
  // with no change in that cycle the measurement is abandoned.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(EXP_PERIOD + TOL);

  // Interval bounds carry one extra bit: timer+1 can exceed LIMIT by one.
  localparam logic [CNT_W:0] LO_EXT = (CNT_W + 1)'(EXP_PERIOD - TOL);
  localparam logic [CNT_W:0] HI_EXT = (CNT_W + 1)'(EXP_PERIOD + TOL);

  logic [1:0]       state;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] timer;
  logic [SW-1:0]    streak;

  logic [CNT_W-1:0] period_r;
  logic             step_valid_r;
  logic             step_err_r;
  logic             period_err_r;
  logic             locked_r;
  logic [7:0]       err_count_r;

  logic             change;
  logic [CNT_W:0]   interval;
  logic             bad_step;
  logic             bad_period;
  logic             timeout;
  logic [SW-1:0]    streak_inc;
  logic [7:0]       err_count_inc;

  // Per-cycle observations. interval is the count a change in this cycle
  // would report; streak/err_count increments are precomputed saturated.
  always_comb begin
    change        = (bus.q_in != q_d);
    interval      = {1'b0, timer} + (CNT_W + 1)'(1);
    bad_step      = (bus.q_in != (q_d + WIDTH'(1)));
    bad_period    = (interval < LO_EXT) || (interval > HI_EXT);
    timeout       = (timer == LIMIT);
    streak_inc    = (streak == LOCK_S) ? streak : (streak + SW'(1));
    err_count_inc = (err_count_r == 8'hFF) ? err_count_r : (err_count_r + 8'd1);
  end

  // Main state machine. PRIME takes a reference sample, ACQUIRE waits for
  // the first change to start timing, MEASURE checks each following change.
  // A change always wins over the timeout in the same cycle, so it is
  // reported as an over-long step rather than as a separate timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= PRIME;
      q_d          <= '0;
      timer        <= '0;
      streak       <= '0;
      period_r     <= '0;
      step_valid_r <= 1'b0;
      step_err_r   <= 1'b0;
      period_err_r <= 1'b0;
      locked_r     <= 1'b0;
      err_count_r  <= 8'd0;
    end else begin
      step_valid_r <= 1'b0;
      step_err_r   <= 1'b0;
      period_err_r <= 1'b0;

      case (state)
        PRIME: begin
          q_d   <= bus.q_in;
          state <= ACQUIRE;
        end

        ACQUIRE: begin
          if (change) begin
            q_d   <= bus.q_in;
            timer <= '0;
            state <= MEASURE;
          end
        end

        MEASURE: begin
          if (change) begin
            period_r     <= interval[CNT_W-1:0];
            step_valid_r <= 1'b1;
            step_err_r   <= bad_step;
            period_err_r <= bad_period;
            q_d          <= bus.q_in;
            timer        <= '0;
            if (bad_step || bad_period) begin
              streak      <= '0;
              locked_r    <= 1'b0;
              err_count_r <= err_count_inc;
            end else begin
              streak   <= streak_inc;
              locked_r <= (streak_inc == LOCK_S);
            end
          end else if (timeout) begin
            period_err_r <= 1'b1;
            streak       <= '0;
            locked_r     <= 1'b0;
            err_count_r  <= err_count_inc;
            timer        <= '0;
            state        <= ACQUIRE;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        default: begin
          state <= PRIME;
        end
      endcase
    end
  end

  assign bus.period     = period_r;
  assign bus.step_valid = step_valid_r;
  assign bus.step_err   = step_err_r;
  assign bus.period_err = period_err_r;
  assign bus.locked     = locked_r;
  assign bus.err_count  = err_count_r;

endmodule
